// File: rtl/jt12_kon_sched_if.sv
// CPU key-on write port and serialized key-on output of the EG key-on scheduler.
interface jt12_kon_sched_if #(parameter int DEPTH = 4);
    logic                     clk_en;
    logic                     zero;
    logic                     wr;
    logic [2:0]               wr_ch;
    logic [3:0]               wr_op;
    logic                     full;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   pending;
    logic [4:0]               slot;
    logic                     keyon_I;

    modport master (
        output clk_en, zero, wr, wr_ch, wr_op,
        input  full, overflow, pending, slot, keyon_I
    );

    modport slave (
        input  clk_en, zero, wr, wr_ch, wr_op,
        output full, overflow, pending, slot, keyon_I
    );
endinterface

// File: rtl/jt12_kon_sched.sv
// Buffers CPU key-on writes, commits at most one per sample at slot 23,
// and serializes the 6x4 key-on array into the 24-slot EG order.
module jt12_kon_sched #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    jt12_kon_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0] cidx;
        logic [3:0] mask;
    } kon_req_t;

    kon_req_t        fifo [DEPTH];
    kon_req_t        head;
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic [4:0]      slot;
    logic [5:0][3:0] kon;
    logic            overflow, keyon;

    logic [2:0] wr_cidx;
    logic       ch_ok;
    logic [4:0] rel;
    logic [1:0] sel_bit;
    logic       boundary, empty, full, pop, push_req, push, drop;

    always_comb begin
        ch_ok   = 1'b1;
        wr_cidx = 3'd0;
        case (bus.wr_ch)
            3'd0:    wr_cidx = 3'd0;
            3'd1:    wr_cidx = 3'd1;
            3'd2:    wr_cidx = 3'd2;
            3'd4:    wr_cidx = 3'd3;
            3'd5:    wr_cidx = 3'd4;
            3'd6:    wr_cidx = 3'd5;
            default: ch_ok   = 1'b0;
        endcase
    end

    // Slot groups run S1, S3, S2, S4, i.e. mask bits 0, 2, 1, 3.
    always_comb begin
        if (slot < 5'd6) begin
            rel     = slot;
            sel_bit = 2'd0;
        end else if (slot < 5'd12) begin
            rel     = slot - 5'd6;
            sel_bit = 2'd2;
        end else if (slot < 5'd18) begin
            rel     = slot - 5'd12;
            sel_bit = 2'd1;
        end else begin
            rel     = slot - 5'd18;
            sel_bit = 2'd3;
        end
    end

    assign head     = fifo[rptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign boundary = bus.clk_en & (slot == 5'd23) & ~bus.zero;
    assign pop      = boundary & ~empty;
    assign push_req = bus.wr & ch_ok;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push)
            fifo[wptr] <= '{cidx: wr_cidx, mask: bus.wr_op};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            slot     <= '0;
            kon      <= '0;
            overflow <= 1'b0;
            keyon    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr           <= rptr + 1'b1;
                kon[head.cidx] <= head.mask;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            // Output uses the pre-commit array, so a commit shows from the next sample.
            if (bus.clk_en) begin
                keyon <= kon[rel[2:0]][sel_bit];
                if (bus.zero || slot == 5'd23)
                    slot <= '0;
                else
                    slot <= slot + 1'b1;
            end
        end
    end

    assign bus.full     = full;
    assign bus.overflow = overflow;
    assign bus.pending  = count;
    assign bus.slot     = slot;
    assign bus.keyon_I  = keyon;
endmodule

// File: tb/tb_jt12_kon_sched.sv
// Scoreboard bench for jt12_kon_sched: queue-based reference model, directed scenarios plus random traffic.
module tb_jt12_kon_sched;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jt12_kon_sched_if #(.DEPTH(DEPTH)) bus ();
    jt12_kon_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int slot;
        bit keyon;
        int pending;
        bit full;
        bit ovf;
    } exp_t;

    typedef struct {
        int       ch;
        bit [3:0] mask;
    } wr_t;

    exp_t     sb[$];
    wr_t      mq[$];
    bit [3:0] mkon[6];
    int       mslot;
    bit       mkey, movf;
    int       vectors    = 0;
    int       miscompares = 0;
    int       chmap[8]   = '{0, 1, 2, -1, 3, 4, 5, -1};
    int       gbit[4]    = '{0, 2, 1, 3};

    initial begin
        bus.clk_en = 1'b0;
        bus.zero   = 1'b0;
        bus.wr     = 1'b0;
        bus.wr_ch  = 3'd0;
        bus.wr_op  = 4'd0;
    end

    // One clk cycle of stimulus; the model predicts outputs after the coming posedge.
    task automatic step(bit r, bit en, bit z, bit w, bit [2:0] ch, bit [3:0] op);
        bit   bnd, do_pop, accept;
        wr_t  hd, nw;
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        bus.clk_en = en;
        bus.zero   = z;
        bus.wr     = w;
        bus.wr_ch  = ch;
        bus.wr_op  = op;
        if (!r) begin
            mq.delete();
            foreach (mkon[i]) mkon[i] = 4'd0;
            mslot = 0;
            mkey  = 1'b0;
            movf  = 1'b0;
        end else begin
            bnd    = en && mslot == 23 && !z;
            do_pop = bnd && mq.size() > 0;
            accept = 1'b0;
            if (w && chmap[ch] >= 0) begin
                if (mq.size() < DEPTH || do_pop) accept = 1'b1;
                else movf = 1'b1;
            end
            if (en) mkey = mkon[mslot % 6][gbit[mslot / 6]];
            if (do_pop) begin
                hd = mq.pop_front();
                mkon[hd.ch] = hd.mask;
            end
            if (accept) begin
                nw.ch   = chmap[ch];
                nw.mask = op;
                mq.push_back(nw);
            end
            if (en) mslot = z ? 0 : (mslot + 1) % 24;
        end
        e.slot    = mslot;
        e.keyon   = mkey;
        e.pending = mq.size();
        e.full    = (mq.size() == DEPTH);
        e.ovf     = movf;
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) step(1, 1, 0, 0, 3'd0, 4'd0);
    endtask

    task automatic write(bit [2:0] ch, bit [3:0] op);
        step(1, 1, 0, 1, ch, op);
    endtask

    task automatic to_slot(int s);
        int guard = 0;
        while (mslot != s && guard < 30) begin
            idle(1);
            guard++;
        end
    endtask

    task automatic do_reset();
        repeat (2) step(0, 1, 0, 0, 3'd0, 4'd0);
    endtask

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("slot",     int'(bus.slot),     e.slot);
            chk("keyon_I",  int'(bus.keyon_I),  int'(e.keyon));
            chk("pending",  int'(bus.pending),  e.pending);
            chk("full",     int'(bus.full),     int'(e.full));
            chk("overflow", int'(bus.overflow), int'(e.ovf));
        end
    end

    initial begin
        do_reset();

        // Single write: ch1 S1+S3 -> slots 1 and 7.
        write(3'd1, 4'b0101);
        idle(24 * 3);

        // Back-to-back off/on edge on ch4.
        write(3'd4, 4'hF);
        idle(48);
        to_slot(2);
        write(3'd4, 4'h0);
        write(3'd4, 4'hF);
        idle(24 * 4);

        // Overflow: five writes with no boundary in between.
        do_reset();
        write(3'd0, 4'hF);
        write(3'd1, 4'hF);
        write(3'd2, 4'hF);
        write(3'd4, 4'hF);
        write(3'd5, 4'hF);
        idle(24 * 5);

        // Invalid channel, then push on the boundary while full.
        do_reset();
        write(3'd3, 4'hF);
        write(3'd7, 4'hA);
        write(3'd0, 4'h1);
        write(3'd1, 4'h2);
        write(3'd2, 4'h4);
        write(3'd4, 4'h8);
        to_slot(23);
        write(3'd6, 4'hC);
        idle(24 * 6);

        // Zero resync at slot 10 with one entry queued.
        write(3'd2, 4'hF);
        to_slot(10);
        step(1, 1, 1, 0, 3'd0, 4'd0);
        idle(24 * 3);

        // Reset mid-run with three entries queued.
        write(3'd0, 4'h3);
        write(3'd5, 4'h5);
        write(3'd6, 4'h9);
        idle(3);
        do_reset();
        idle(30);

        // Random traffic with gated clk_en, stray zeros and occasional reset.
        repeat (3000) begin
            step($urandom_range(0, 599) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 5) == 0,
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
        end
        idle(24 * 5);

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expected 0 pending checks", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
